// File: rtl/vec_deserializer_pkg.sv
// Shared types for the vector deserializer and the reduction blocks that
// consume its output: lane width, FSM state encoding and vector typedef.
package vec_deserializer_pkg;

    // Bits per lane.
    localparam int LANE_W       = 8;
    // Default number of lanes per vector (legal range 2..64).
    localparam int DEF_ELEMENTS = 12;

    typedef logic [LANE_W-1:0] lane_t;

    // Packed vector at the default lane count; lane 0 is the first element.
    typedef lane_t [DEF_ELEMENTS-1:0] vec_t;

    // FILL: collecting elements. HOLD: a completed vector waits for the
    // output register to drain.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage : vec_deserializer_pkg

// File: rtl/vec_deserializer_if.sv
// Element-in / vector-out handshake bundle. The slave modport is the
// deserializer's view; the master modport is the environment's view.
interface vec_deserializer_if
    import vec_deserializer_pkg::*;
#(
    parameter int ELEMENTS = DEF_ELEMENTS
) ();

    localparam int CNT_W = $clog2(ELEMENTS + 1);

    // Upstream element stream
    logic                      s_valid;
    lane_t                     s_data;
    logic                      s_last;
    logic                      s_ready;

    // Downstream vector stream
    logic                      m_valid;
    lane_t [ELEMENTS-1:0]      m_data;
    logic [CNT_W-1:0]          m_count;
    logic                      m_ready;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );

endinterface : vec_deserializer_if

// File: rtl/vec_deserializer.sv
// Packs a stream of LANE_W-bit elements into vectors of up to ELEMENTS lanes.
// A vector closes on its last lane or on s_last; unused lanes read zero.
// One completed vector can wait in the fill buffer (HOLD) while the output
// register is occupied, so a full-rate stream never bubbles at boundaries.
module vec_deserializer
    import vec_deserializer_pkg::*;
#(
    parameter int ELEMENTS = DEF_ELEMENTS   // legal range 2..64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    vec_deserializer_if.slave    bus
);

    localparam int IDX_W = $clog2(ELEMENTS);
    localparam int CNT_W = $clog2(ELEMENTS + 1);

    // Registers
    state_e                r_state;
    logic                  r_rdy_en;     // low during reset, high from the first edge after
    logic [IDX_W-1:0]      r_idx;        // next lane to fill
    lane_t [ELEMENTS-1:0]  r_buf;        // fill buffer; doubles as pending vector in HOLD
    logic [CNT_W-1:0]      r_pend_cnt;   // lane count of the pending vector
    logic                  r_m_valid;
    lane_t [ELEMENTS-1:0]  r_m_data;
    logic [CNT_W-1:0]      r_m_count;

    // Wires
    state_e                w_state_next;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_is_end;
    logic                  w_complete;
    logic                  w_load_fill;  // completed vector goes straight to output
    logic                  w_park;       // completed vector waits in the fill buffer
    logic                  w_load_pend;  // pending vector moves to output
    lane_t [ELEMENTS-1:0]  w_fill_vec;   // fill buffer with this cycle's element written in
    logic [CNT_W-1:0]      w_fill_cnt;

    assign w_s_ready  = r_rdy_en && (r_state == ST_FILL);
    assign w_accept   = bus.s_valid && w_s_ready;
    assign w_xfer     = r_m_valid && bus.m_ready;
    assign w_is_end   = (r_idx == IDX_W'(ELEMENTS - 1));
    assign w_complete = w_accept && (bus.s_last || w_is_end);
    assign w_fill_cnt = CNT_W'(r_idx) + CNT_W'(1);

    // Lane write decode: merge the incoming element into lane [r_idx].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_fill_vec = r_buf;
        for (int i = 0; i < ELEMENTS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_fill_vec[i] = bus.s_data;
            end
        end
    end

    // FSM next-state and datapath steering.
    always_comb begin
        w_state_next = r_state;
        w_load_fill  = 1'b0;
        w_park       = 1'b0;
        w_load_pend  = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_complete) begin
                    if (!r_m_valid || bus.m_ready) begin
                        w_load_fill = 1'b1;
                    end else begin
                        w_park       = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // The output register is always occupied in HOLD, so m_ready alone means a transfer.
                if (bus.m_ready) begin
                    w_load_pend  = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    // State register and post-reset ready enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            r_state  <= ST_FILL;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rdy_en <= 1'b1;
        end
    end

    // Fill index: advance per accepted element, wrap to 0 on completion.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_idx <= '0;
        end else if (w_complete) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Fill buffer: collect lanes, park a completed vector, clear after hand-off.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: the lane buffer is reset and cleared after each hand-off because unused lanes must read zero.
        if (rst_in) begin
            r_buf      <= '0;
            r_pend_cnt <= '0;
        end else if (w_park) begin
            r_buf      <= w_fill_vec;
            r_pend_cnt <= w_fill_cnt;
        end else if (w_load_fill || w_load_pend) begin
            r_buf      <= '0;
        end else if (w_accept) begin
            r_buf      <= w_fill_vec;
        end
    end

    // Output register: load a completed or pending vector, drop valid after a bare transfer.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_count <= '0;
        end else if (w_load_fill) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_fill_vec;
            r_m_count <= w_fill_cnt;
        end else if (w_load_pend) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_buf;
            r_m_count <= r_pend_cnt;
        end else if (w_xfer) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_count = r_m_count;

endmodule : vec_deserializer

// File: tb/tb_vec_deserializer.sv
// Self-checking bench for vec_deserializer with ELEMENTS=4. A queue-based
// model tracks completed-but-untransferred vectors; directed scenarios pin
// the model with literal values, then a randomized run exercises the rest.
module tb_vec_deserializer;
    import vec_deserializer_pkg::*;

    localparam int E  = 4;
    localparam int VW = E * LANE_W;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    vec_deserializer_if #(.ELEMENTS(E)) vif ();

    vec_deserializer #(.ELEMENTS(E)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (vif)
    );

    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Expected output stream is the queue of completed vectors not yet
    // transferred. Output is valid whenever that queue is non-empty; input is
    // ready whenever fewer than two are outstanding (one shown, one parked).
    typedef struct {
        logic [VW-1:0] data;
        int            count;
    } vec_s;

    vec_s          exp_q[$];
    logic [VW-1:0] cur_data = '0;
    int            cur_n    = 0;
    bit            rdy_ok   = 1'b0;
    bit            m_exp_valid, m_exp_ready, m_acc, m_xfer;

    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            cur_data = '0;
            cur_n    = 0;
            rdy_ok   = 1'b0;
            check("rst_m_valid", 64'(vif.m_valid), 64'd0);
            check("rst_s_ready", 64'(vif.s_ready), 64'd0);
            check("rst_m_count", 64'(vif.m_count), 64'd0);
            check("rst_m_data",  64'(vif.m_data),  64'd0);
        end else begin
            m_exp_valid = (exp_q.size() > 0);
            m_exp_ready = rdy_ok && (exp_q.size() < 2);
            check("m_valid", 64'(vif.m_valid), 64'(m_exp_valid));
            check("s_ready", 64'(vif.s_ready), 64'(m_exp_ready));
            if (m_exp_valid) begin
                check("m_data",  64'(vif.m_data),  64'(exp_q[0].data));
                check("m_count", 64'(vif.m_count), 64'(exp_q[0].count));
            end
            // Handshakes that will happen on the coming rising edge.
            m_acc  = vif.s_valid && m_exp_ready;
            m_xfer = m_exp_valid && vif.m_ready;
            if (m_xfer) void'(exp_q.pop_front());
            if (m_acc) begin
                cur_data[cur_n*LANE_W +: LANE_W] = vif.s_data;
                cur_n++;
                if (cur_n == E || vif.s_last) begin
                    exp_q.push_back(vec_s'{data: cur_data, count: cur_n});
                    cur_data = '0;
                    cur_n    = 0;
                end
            end
            rdy_ok = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one element and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input bit last);
        int  waited = 0;
        bit  done   = 1'b0;
        vif.s_valid = 1'b1;
        vif.s_data  = d;
        vif.s_last  = last;
        while (!done) begin
            @(negedge clk_in);
            done = vif.s_ready;
            tick();
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    check("send_timeout", 64'(waited), 64'd0);
                    break;
                end
            end
        end
        vif.s_valid = 1'b0;
        vif.s_last  = 1'b0;
    endtask

    logic [31:0] exp36 [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    int          vec_cyc [3];
    int          t0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vif.s_valid = 1'b0;
        vif.s_data  = '0;
        vif.s_last  = 1'b0;
        vif.m_ready = 1'b0;
        rst_in      = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Full vector, output free: valid one cycle after the fourth byte.
        vif.m_ready = 1'b1;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        check("full_valid", 64'(vif.m_valid), 64'd1);
        check("full_data",  64'(vif.m_data),  64'h04030201);
        check("full_count", 64'(vif.m_count), 64'd4);

        // Short vector terminated by s_last, zero-filled upper lanes.
        send(8'd9, 1'b0);
        send(8'd8, 1'b1);
        check("short_data",  64'(vif.m_data),  64'h00000809);
        check("short_count", 64'(vif.m_count), 64'd2);
        // Next vector restarts at lane 0.
        send(8'd7, 1'b1);
        check("restart_data",  64'(vif.m_data),  64'h00000007);
        check("restart_count", 64'(vif.m_count), 64'd1);
        tick();
        tick();

        // Backpressure: second vector parks, input stalls.
        vif.m_ready = 1'b0;
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("bp_cycles",  64'(cyc - t0),     64'd8);
        check("bp_s_ready", 64'(vif.s_ready),  64'd0);
        check("bp_hold",    64'(vif.m_data),   64'h04030201);
        vif.m_ready = 1'b1;
        tick();
        check("bp_next_data",  64'(vif.m_data),  64'h08070605);
        check("bp_next_valid", 64'(vif.m_valid), 64'd1);
        check("bp_s_ready_up", 64'(vif.s_ready), 64'd1);
        tick();
        check("bp_drained", 64'(vif.m_valid), 64'd0);

        // Continuous stream: one element per cycle, vectors four cycles apart.
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            send(8'(i), 1'b0);
            if (i % 4 == 3) begin
                check("stream_data", 64'(vif.m_data), 64'(exp36[i/4]));
                vec_cyc[i/4] = cyc;
            end
        end
        check("stream_cycles", 64'(cyc - t0), 64'd12);
        check("stream_gap1", 64'(vec_cyc[1] - vec_cyc[0]), 64'd4);
        check("stream_gap2", 64'(vec_cyc[2] - vec_cyc[1]), 64'd4);
        tick();

        // Reset mid-vector discards output and partial data.
        vif.m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        rst_in = 1'b1;
        #1;
        check("midrst_valid", 64'(vif.m_valid), 64'd0);
        check("midrst_ready", 64'(vif.s_ready), 64'd0);
        tick();
        tick();
        rst_in = 1'b0;
        vif.m_ready = 1'b1;
        send(8'd5, 1'b0);
        send(8'd6, 1'b0);
        send(8'd7, 1'b0);
        send(8'd8, 1'b0);
        check("postrst_data",  64'(vif.m_data),  64'h08070605);
        check("postrst_count", 64'(vif.m_count), 64'd4);
        tick();

        // Randomized traffic across three backpressure levels.
        for (int k = 0; k < 3000; k++) begin
            int rdy_pct;
            rdy_pct     = (k < 1000) ? 9 : (k < 2000) ? 5 : 2;
            vif.s_valid = ($urandom_range(0, 9) < 7);
            vif.s_data  = 8'($urandom);
            vif.s_last  = ($urandom_range(0, 4) == 0);
            vif.m_ready = ($urandom_range(0, 9) < rdy_pct);
            rst_in      = ($urandom_range(0, 399) == 0);
            tick();
        end

        rst_in      = 1'b0;
        vif.s_valid = 1'b0;
        vif.s_last  = 1'b0;
        vif.m_ready = 1'b1;
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_vec_deserializer

// File: doc/vec_deserializer.md
VEC_DESERIALIZER -- requirements
Module: vec_deserializer

Interface
REQ-001 ELEMENTS, 12, lanes per output vector; legal range 2..64.
REQ-002 WIDTH, 8, bits per lane.
REQ-003 clk_in  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_in  input  1  reset; asynchronous and active-high.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 s_data  input  WIDTH  upstream element.
REQ-007 s_last  input  1  element is the final one of the current vector; qualified by s_valid.
REQ-008 s_ready  output  1  block accepts an element this cycle.
REQ-009 m_valid  output  1  output vector valid.
REQ-010 m_data  output  [ELEMENTS-1:0][WIDTH-1:0]  packed output vector; lane 0 is the first element accepted.
REQ-011 m_count  output  $clog2(ELEMENTS+1)  number of populated lanes, 1..ELEMENTS.
REQ-012 m_ready  input  1  downstream accepts the vector this cycle.

Function
REQ-013 An element SHALL be accepted only on a cycle where s_valid and s_ready are both 1; a vector SHALL be transferred only on a cycle where m_valid and m_ready are both 1.
REQ-014 A fill index SHALL start at 0, write each accepted element into lane [index], and increment by 1 per accepted element.
REQ-015 A vector SHALL complete when either:
- the element at index ELEMENTS-1 is accepted, or
- an element with s_last=1 is accepted.
REQ-016 On completion the fill index SHALL wrap to 0, and m_count SHALL be set to (index+1).
REQ-017 Lanes at or above m_count SHALL read 0; no stale data from a previous vector SHALL appear.
REQ-018 The state machine SHALL have two states, FILL and HOLD:
- FILL: s_ready=1.
- HOLD: s_ready=0.
REQ-019 In FILL, when a vector completes and the output register is free (m_valid=0, or a transfer occurs in the same cycle), the completed vector, including the element accepted that cycle, SHALL load into m_data/m_count, with m_valid=1 on the next cycle.
REQ-020 In FILL, when a vector completes and the output register is occupied and not transferring, the fill buffer SHALL be retained and the state SHALL go to HOLD.
REQ-021 In HOLD, on a transfer the pending vector SHALL load into the output register, m_valid SHALL remain 1, and the state SHALL return to FILL.
REQ-022 Latency from acceptance of the completing element to m_valid=1 SHALL be exactly 1 cycle when the output register is free.
REQ-023 With s_valid=1 and m_ready=1 held continuously, throughput SHALL be 1 element per cycle, with no bubble at vector boundaries.
REQ-024 When a transfer occurs and no new vector completes in the same cycle, m_valid SHALL deassert on the next cycle.
REQ-025 While m_valid=1 and m_ready=0, m_data and m_count SHALL hold stable.
REQ-026 s_last on the element at index ELEMENTS-1 SHALL be equivalent to a full vector (m_count=ELEMENTS).
REQ-027 s_data and s_last SHALL be ignored when s_valid=0 or s_ready=0.

Reset
REQ-028 While rst_in=1, the block SHALL hold: state=FILL, fill index=0, fill buffer=0, m_valid=0, m_data=0, m_count=0, s_ready=0.
REQ-029 s_ready SHALL assert on the first clk_in edge after rst_in deasserts.
REQ-030 Reset asserted mid-vector or in HOLD SHALL discard all partial and pending data; no vector SHALL be emitted for it.

Structure
REQ-031 A shared package SHALL hold:
- the lane-width constant (8),
- the FILL/HOLD state enum,
- the packed vector typedef reused by downstream reduction blocks.
REQ-032 No sub-module SHALL be instantiated; the fill counter, lane write decode and output register SHALL be implemented inline.

Verification (ELEMENTS=4)
REQ-033 Reset release, then bytes 1,2,3,4 on consecutive cycles with m_ready=1 -> m_valid=1 in the cycle after byte 4, with m_data={4,3,2,1} and m_count=4.
REQ-034 Bytes 9,8 with s_last on 8 -> m_data={0,0,8,9}, m_count=2; the next vector starts at lane 0.
REQ-035 m_ready=0, stream 8 bytes 1..8 -> first vector {4,3,2,1} held stable; second vector completes into HOLD with s_ready=0; raise m_ready -> {8,7,6,5} presented next cycle; s_ready returns to 1.
REQ-036 Continuous stream 0..11 with m_ready=1 -> three vectors on cycles N, N+4, N+8 with no s_ready deassertion.
REQ-037 Assert rst_in after 2 bytes of a vector -> m_valid=0 immediately; after release, bytes 5,6,7,8 -> m_data={8,7,6,5} only.
